// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   rnum_t;

  localparam int NUM_ROUNDS      = 10;
  localparam int LAST_FULL_ROUND = NUM_ROUNDS - 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    LISSUE,
    LWAIT,
    OUT
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: initial AddRoundKey, rounds 1..9 on the round stage, then lastRound.
// Optional stage-done watchdog with sticky err output enabled by AES_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a plaintext/key pair
// ISSUE  | rnd_en pulse for round round_cnt
// WAIT   | waiting for rnd_done
// LISSUE | lr_en pulse for the final round
// LWAIT  | waiting for lr_done
// OUT    | ciphertext offered until accepted
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  block_t in_pt,
  input  block_t in_key,
  output logic   rnd_en,
  output block_t rnd_state,
  output block_t rnd_key,
  output rnum_t  rnd_num,
  input  logic   rnd_done,
  input  block_t rnd_state_out,
  input  block_t rnd_key_out,
  output logic   lr_en,
  output block_t lr_state,
  output block_t lr_key,
  input  logic   lr_done,
  input  block_t lr_state_out,
  output logic   out_valid,
  input  logic   out_ready,
  output block_t out_ct,
`ifdef AES_SEQ_TIMEOUT_EN
  output logic   err,
`endif
  output logic   busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  seq_state_e st_q;
  block_t     state_q;
  block_t     key_q;
  rnum_t      round_cnt_q;
  block_t     out_ct_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       rnd_en_q;
  logic       lr_en_q;
  logic       out_valid_q;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Loaded so that err rises exactly TIMEOUT_CYCLES cycles after the start pulse.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYCLES - 2);
  logic [CW-1:0] wait_cnt_q;
  logic          err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_cnt_q <= '0;
      out_ct_q    <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      rnd_en_q    <= 1'b0;
      lr_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      rnd_en_q <= 1'b0;
      lr_en_q  <= 1'b0;
      case (st_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q     <= in_pt ^ in_key;
            key_q       <= in_key;
            round_cnt_q <= rnum_t'(1);
            rnd_en_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            st_q        <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef AES_SEQ_TIMEOUT_EN
          wait_cnt_q <= WAIT_LOAD;
`endif
          st_q <= WAIT;
        end
        WAIT: begin
          if (rnd_done) begin
            state_q <= rnd_state_out;
            key_q   <= rnd_key_out;
            if (round_cnt_q == rnum_t'(LAST_FULL_ROUND)) begin
              lr_en_q <= 1'b1;
              st_q    <= LISSUE;
            end else begin
              round_cnt_q <= round_cnt_q + rnum_t'(1);
              rnd_en_q    <= 1'b1;
              st_q        <= ISSUE;
            end
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == '0) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            st_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
`endif
        end
        LISSUE: begin
`ifdef AES_SEQ_TIMEOUT_EN
          wait_cnt_q <= WAIT_LOAD;
`endif
          st_q <= LWAIT;
        end
        LWAIT: begin
          if (lr_done) begin
            out_ct_q    <= lr_state_out;
            out_valid_q <= 1'b1;
            st_q        <= OUT;
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == '0) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            st_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            st_q        <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          st_q        <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign rnd_en    = rnd_en_q;
  assign rnd_state = state_q;
  assign rnd_key   = key_q;
  assign rnd_num   = round_cnt_q;
  assign lr_en     = lr_en_q;
  assign lr_state  = state_q;
  assign lr_key    = key_q;
  assign out_valid = out_valid_q;
  assign out_ct    = out_ct_q;
`ifdef AES_SEQ_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with behavioural round/lastRound stages around it.
// Define AES_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_pt = '0;
  logic [127:0] in_key = '0;
  logic         rnd_en;
  logic [127:0] rnd_state, rnd_key;
  logic [3:0]   rnd_num;
  logic         rnd_done;
  logic [127:0] rnd_state_out, rnd_key_out;
  logic         lr_en;
  logic [127:0] lr_state, lr_key;
  logic         lr_done;
  logic [127:0] lr_state_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         busy;
`ifdef AES_SEQ_TIMEOUT_EN
  logic         err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .rnd_en(rnd_en), .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_num(rnd_num),
    .rnd_done(rnd_done), .rnd_state_out(rnd_state_out), .rnd_key_out(rnd_key_out),
    .lr_en(lr_en), .lr_state(lr_state), .lr_key(lr_key),
    .lr_done(lr_done), .lr_state_out(lr_state_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
`ifdef AES_SEQ_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference functions (byte 0 in [127:120]) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = xt(r);
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input int n);
    logic [31:0] t, w0, w1, w2, w3;
    t = {k[23:0], k[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(n), 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- behavioural round / lastRound stages ----------------
  int           r_lat = 2, l_lat = 3;
  int           r_cnt = 0, l_cnt = 0;
  logic [127:0] r_st_res = '0, r_key_res = '0, l_res = '0;
  logic         spur_rnd = 1'b0, spur_lr = 1'b0, stub_rnd = 1'b0;

  always @(posedge clk) begin
    if (rnd_en) begin
      r_key_res <= key_next(rnd_key, int'(rnd_num));
      r_st_res  <= mix_cols(shift_rows(sub_bytes(rnd_state))) ^ key_next(rnd_key, int'(rnd_num));
      r_cnt     <= r_lat;
    end else if (r_cnt > 0) begin
      r_cnt <= r_cnt - 1;
    end
    if (lr_en) begin
      l_res <= shift_rows(sub_bytes(lr_state)) ^ key_next(lr_key, 10);
      l_cnt <= l_lat;
    end else if (l_cnt > 0) begin
      l_cnt <= l_cnt - 1;
    end
  end

  assign rnd_done      = ((r_cnt == 1) && !stub_rnd) || spur_rnd;
  assign rnd_state_out = r_st_res;
  assign rnd_key_out   = r_key_res;
  assign lr_done       = (l_cnt == 1) || spur_lr;
  assign lr_state_out  = l_res;

  // ---------------- checking ----------------
  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic run_vec(input string nm, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp_first, input logic [127:0] exp_ct,
                         input int lat_r, input int lat_l, input bit rdy_early, input int hold);
    int cyc, n_en, n_lr;
    bit seq_ok, hs_ok, stab_ok;
    logic [127:0] first_st;
    r_lat = lat_r; l_lat = lat_l;
    in_pt = pt; in_key = key; in_valid = 1'b1; out_ready = rdy_early;
    check_vec({nm, "_in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1; n_en = 0; n_lr = 0; seq_ok = 1; hs_ok = 1; first_st = '0;
    while (!out_valid && cyc < 400) begin
      if (rnd_en) begin
        if (n_en == 0) first_st = rnd_state;
        if (int'(rnd_num) != n_en + 1 || n_lr != 0) seq_ok = 0;
        n_en++;
      end
      if (lr_en) n_lr++;
      if (in_ready || !busy) hs_ok = 0;
      @(negedge clk);
      cyc++;
    end
    check_vec({nm, "_latency"}, cyc, 1 + 9 * (1 + lat_r) + (1 + lat_l));
    check_vec({nm, "_first_rnd_state"}, first_st, exp_first);
    check_vec({nm, "_rnd_en_count"}, n_en, 9);
    check_vec({nm, "_lr_en_count"}, n_lr, 1);
    check_vec({nm, "_rnd_num_order"}, seq_ok, 1);
    check_vec({nm, "_ready0_busy1"}, hs_ok, 1);
    check_vec({nm, "_out_ct"}, out_ct, exp_ct);
    if (!rdy_early) begin
      stab_ok = 1;
      for (int i = 0; i < hold; i++) begin
        spur_rnd = (i == 5); spur_lr = (i == 5);
        @(negedge clk);
        if (out_ct !== exp_ct || !out_valid || in_ready || !busy) stab_ok = 0;
      end
      spur_rnd = 1'b0; spur_lr = 1'b0;
      check_vec({nm, "_hold_stable"}, stab_ok, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_vec({nm, "_out_valid_after_xfer"}, out_valid, 0);
    check_vec({nm, "_in_ready_after_xfer"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_R1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_R1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int n;
    bit quiet, stale_seen;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_out_ct", out_ct, 0);
    check_vec("rst_pulses", {rnd_en, lr_en}, 0);
    check_vec("rst_rnd_state", rnd_state, 0);
    check_vec("rst_rnd_num", rnd_num, 0);
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with a 20-cycle consumer stall, then FIPS-197 B back to back
    run_vec("c1", C1_PT, C1_KY, C1_R1, C1_CT, 2, 3, 1'b0, 20);
    run_vec("b", B_PT, B_KY, B_R1, B_CT, 1, 1, 1'b1, 0);

    // stray done pulses while idle
    spur_rnd = 1'b1; spur_lr = 1'b1;
    @(negedge clk);
    spur_rnd = 1'b0; spur_lr = 1'b0;
    @(negedge clk);
    check_vec("idle_spur_busy", busy, 0);
    check_vec("idle_spur_in_ready", in_ready, 1);
    check_vec("idle_spur_out_valid", out_valid, 0);
    check_vec("idle_spur_out_ct", out_ct, B_CT);

    // abort with reset while waiting on round 5
    r_lat = 3;
    in_pt = C1_PT; in_key = C1_KY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(rnd_en && rnd_num == 4'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_vec("rst_reach_round5", n < 200, 1);
    @(negedge clk);
    check_vec("wait_r5_num", rnd_num, 5);
    check_vec("wait_r5_busy", busy, 1);
    rst = 1'b0;
    #1;
    check_vec("abort_in_ready", in_ready, 1);
    check_vec("abort_busy", busy, 0);
    check_vec("abort_pulses", {rnd_en, lr_en, out_valid}, 0);
    check_vec("abort_rnd_state", rnd_state, 0);
    check_vec("abort_rnd_key", rnd_key, 0);
    check_vec("abort_rnd_num", rnd_num, 0);
    check_vec("abort_out_ct", out_ct, 0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1; stale_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rnd_done) stale_seen = 1;
      @(negedge clk);
      if (busy || rnd_en || lr_en || out_valid || !in_ready) quiet = 0;
    end
    check_vec("stale_done_present", stale_seen, 1);
    check_vec("stale_done_ignored", quiet, 1);

    run_vec("c1_again", C1_PT, C1_KY, C1_R1, C1_CT, 4, 2, 1'b1, 0);

`ifdef AES_SEQ_TIMEOUT_EN
    check_vec("err_before_timeout", err, 0);
    stub_rnd = 1'b1;
    in_pt = B_PT; in_key = B_KY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_vec("to_rnd_en", rnd_en, 1);
    n = 0; quiet = 1;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) quiet = 0;
    end
    check_vec("to_err_delay", n, 64);
    check_vec("to_busy", busy, 0);
    check_vec("to_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check_vec("to_err_sticky", err, 1);
    check_vec("to_no_out_valid", quiet && !out_valid, 1);
    stub_rnd = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
